// File: rtl/fft_tone_sequencer.sv
// Frame sequencer feeding MCU samples to the FFT engine with paced chip-enables,
// then draining the engine until the tone detector reports (or times out / aborts).
module fft_tone_sequencer #(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_SAMPLES = 128,
    parameter int CE_PERIOD   = 5,
    parameter int TIMEOUT     = 4096,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                sample_valid,
    input  logic                ack,
    input  logic                abort,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                eng_sync,
    input  logic                td_done,
    input  logic [SAMPLE_W-1:0] td_tone,
    output logic                eng_rst,
    output logic                td_rst_n,
    output logic                eng_ce,
    output logic [SAMPLE_W-1:0] eng_sample,
    output logic                td_enable,
    output logic                req_sample,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code,
    output logic [SAMPLE_W-1:0] result,
    output logic [CNT_W-1:0]    sample_count
);

    localparam int PACE_W = $clog2(CE_PERIOD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [PACE_W-1:0] PACE_LAST  = PACE_W'(CE_PERIOD - 2);
    localparam logic [PACE_W-1:0] PHASE_LAST = PACE_W'(CE_PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  FULL       = CNT_W'(NUM_SAMPLES);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        PACE,
        DRAIN,
        DONE,
        ERROR
    } state_t;

    state_t            state_reg;
    logic [PACE_W-1:0] pace_reg;
    logic [TO_W-1:0]   timeout_reg;
    logic              active;

    assign active = (state_reg == ARM) || (state_reg == WAIT) ||
                    (state_reg == PACE) || (state_reg == DRAIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            pace_reg     <= '0;
            timeout_reg  <= '0;
            eng_rst      <= 1'b1;
            td_rst_n     <= 1'b0;
            eng_ce       <= 1'b0;
            eng_sample   <= '0;
            td_enable    <= 1'b0;
            req_sample   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_code     <= 2'b00;
            result       <= '0;
            sample_count <= '0;
        end else if (active && abort) begin
            // Abort outranks every other transition, td_done and timeout included.
            state_reg  <= ERROR;
            err_code   <= ERR_ABORT;
            eng_rst    <= 1'b1;
            eng_ce     <= 1'b0;
            req_sample <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ARM;
                        eng_rst      <= 1'b0;
                        td_rst_n     <= 1'b1;
                        sample_count <= '0;
                        err_code     <= 2'b00;
                        result       <= '0;
                        busy         <= 1'b1;
                    end
                end
                ARM: begin
                    state_reg  <= WAIT;
                    req_sample <= 1'b1;
                end
                WAIT: begin
                    if (sample_valid) begin
                        state_reg  <= PACE;
                        eng_sample <= sample_in;
                        eng_ce     <= 1'b1;
                        req_sample <= 1'b0;
                        pace_reg   <= '0;
                        if (sample_count != FULL) begin
                            sample_count <= sample_count + 1'b1;
                        end
                    end
                end
                PACE: begin
                    eng_ce <= 1'b0;
                    if (pace_reg == PACE_LAST) begin
                        pace_reg <= '0;
                        if (sample_count == FULL) begin
                            state_reg   <= DRAIN;
                            timeout_reg <= '0;
                        end else begin
                            state_reg  <= WAIT;
                            req_sample <= 1'b1;
                        end
                    end else begin
                        pace_reg <= pace_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (eng_sync) begin
                        td_enable <= 1'b1;
                    end
                    if (td_done) begin
                        state_reg <= DONE;
                        result    <= td_tone;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        eng_ce    <= 1'b0;
                    end else if (timeout_reg == TO_LAST) begin
                        state_reg <= ERROR;
                        err_code  <= ERR_TIMEOUT;
                        eng_rst   <= 1'b1;
                        eng_ce    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        // Phase 0 is the entry cycle, so the first pulse lands one cycle later.
                        timeout_reg <= timeout_reg + 1'b1;
                        eng_ce      <= (pace_reg == '0);
                        pace_reg    <= (pace_reg == PHASE_LAST) ? '0 : pace_reg + 1'b1;
                    end
                end
                DONE, ERROR: begin
                    if (ack) begin
                        state_reg    <= IDLE;
                        eng_rst      <= 1'b1;
                        td_rst_n     <= 1'b0;
                        eng_ce       <= 1'b0;
                        eng_sample   <= '0;
                        td_enable    <= 1'b0;
                        req_sample   <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b0;
                        err_code     <= 2'b00;
                        sample_count <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_tone_sequencer.sv
// Directed-sequence bench for fft_tone_sequencer with randomized samples, gaps and tones,
// checked against timing rules computed arithmetically inside the bench.
module tb_fft_tone_sequencer;

    localparam int SW = 16;
    localparam int NS = 8;
    localparam int CP = 5;
    localparam int TO = 64;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, sample_valid, ack, abort, eng_sync, td_done;
    logic [SW-1:0] sample_in, td_tone;
    logic          eng_rst, td_rst_n, eng_ce, td_enable, req_sample, busy, done;
    logic [SW-1:0] eng_sample, result;
    logic [1:0]    err_code;
    logic [CW-1:0] sample_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int di     = 0;
    int last_pulse = 0;
    int mon_cyc    = 0;
    int mon_last   = -1000;
    logic [SW-1:0] exp_result = '0;

    always #5 clk = ~clk;

    fft_tone_sequencer #(
        .SAMPLE_W(SW), .NUM_SAMPLES(NS), .CE_PERIOD(CP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
        .ack(ack), .abort(abort), .sample_in(sample_in), .eng_sync(eng_sync),
        .td_done(td_done), .td_tone(td_tone), .eng_rst(eng_rst), .td_rst_n(td_rst_n),
        .eng_ce(eng_ce), .eng_sample(eng_sample), .td_enable(td_enable),
        .req_sample(req_sample), .busy(busy), .done(done), .err_code(err_code),
        .result(result), .sample_count(sample_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Any eng_ce pulse must be at least CP cycles after the previous one (reset clears history).
    always @(negedge clk) begin
        mon_cyc++;
        if (reset_n !== 1'b1) begin
            mon_last = -1000;
        end else if (eng_ce === 1'b1) begin
            chk("ce_spacing", 32'(mon_cyc - mon_last >= CP), 32'd1);
            mon_last = mon_cyc;
        end
    end

    task automatic chk_rest(input string tag);
        // {eng_rst, td_rst_n, eng_ce, td_enable, req_sample, busy, done, err_code}
        chk({tag, "_ctl"}, {eng_rst, td_rst_n, eng_ce, td_enable, req_sample, busy, done, err_code},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        chk({tag, "_eng_sample"}, eng_sample, '0);
        chk({tag, "_result"}, result, exp_result);
        chk({tag, "_count"}, sample_count, '0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_result = '0;
        chk("wait_req", req_sample, 1);
        chk("wait_ctl", {busy, eng_rst, td_rst_n, err_code}, {1'b1, 1'b0, 1'b1, 2'b00});
        chk("wait_count", sample_count, 0);
        chk("wait_result", result, 0);
    endtask

    // Assumes req_sample is currently high; feeds n samples.
    task automatic feed(input int n, input bit directed);
        for (int i = 1; i <= n; i++) begin
            int d;
            int cnt;
            logic [SW-1:0] v;
            d = directed ? 0 : int'($urandom_range(0, 3));
            v = directed ? SW'(i) : SW'($urandom);
            sample_valid = 1'b0;
            repeat (d) begin
                tick();
                chk("req_hold", req_sample, 1);
            end
            sample_valid = 1'b1;
            sample_in = v;
            tick();
            chk("acc_ce", eng_ce, 1);
            chk("acc_sample", eng_sample, v);
            chk("acc_count", sample_count, i);
            chk("acc_req", req_sample, 0);
            if (i > 1) chk("ce_gap", cyc - last_pulse, CP + d);
            last_pulse = cyc;
            if (i < n) begin
                cnt = 0;
                do begin
                    if (!directed) begin
                        sample_valid = 1'($urandom);
                        sample_in = SW'($urandom);
                    end
                    tick();
                    cnt++;
                end while (!req_sample && cnt < 20);
                chk("pace_len", cnt, CP - 1);
                chk("pace_hold", eng_sample, v);
            end
        end
    endtask

    task automatic to_drain();
        sample_valid = 1'b0;
        repeat (CP - 1) begin
            tick();
            chk("pace_ce", eng_ce, 0);
            chk("pace_req", req_sample, 0);
        end
        di = 0;
        chk("drain_count", sample_count, NS);
        chk("drain_busy", busy, 1);
    endtask

    task automatic drain_run(input int k);
        repeat (k) begin
            tick();
            di++;
            chk("drain_ce", eng_ce, 32'(di % CP == 1));
        end
    endtask

    task automatic sync_pulse();
        chk("td_en_before", td_enable, 0);
        eng_sync = 1'b1;
        drain_run(1);
        eng_sync = 1'b0;
        chk("td_en_after", td_enable, 1);
    endtask

    task automatic finish_result(input logic [SW-1:0] tone, input bit hold_start);
        td_tone = tone;
        td_done = 1'b1;
        tick();
        td_done = 1'b0;
        exp_result = tone;
        chk("done_flag", {done, busy, eng_ce, err_code}, {1'b1, 1'b0, 1'b0, 2'b00});
        chk("done_result", result, tone);
        tick();
        chk("done_held", {done, result}, {1'b1, tone});
        ack = 1'b1;
        start = hold_start;
        tick();
        ack = 1'b0;
        chk_rest("ack_idle");
        if (hold_start) begin
            tick();
            start = 1'b0;
            chk("restart_arm", {busy, eng_rst}, {1'b1, 1'b0});
            tick();
            chk("restart_req", req_sample, 1);
            exp_result = '0;
        end
    endtask

    initial begin
        // Reset with random inputs on every line
        reset_n = 1'b0;
        repeat (3) begin
            start = 1'($urandom); sample_valid = 1'($urandom); ack = 1'($urandom);
            abort = 1'($urandom); eng_sync = 1'($urandom); td_done = 1'($urandom);
            sample_in = SW'($urandom); td_tone = SW'($urandom);
            tick();
        end
        chk_rest("reset");
        {start, sample_valid, ack, abort, eng_sync, td_done} = '0;
        sample_in = '0;
        td_tone = '0;
        reset_n = 1'b1;
        tick();
        chk_rest("idle");

        // Directed full frame 1..8, sync then tone 0x1234
        start_frame();
        feed(NS, 1'b1);
        to_drain();
        drain_run(7);
        sync_pulse();
        drain_run(3);
        chk("drain_sample_held", eng_sample, NS);
        finish_result(16'h1234, 1'b0);

        // Abort in PACE after the third sample
        start_frame();
        feed(3, 1'b0);
        sample_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        chk("abort_state", {err_code, eng_rst, eng_ce, busy, done}, {2'b10, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (3) begin
            tick();
            chk("abort_hold", {err_code, eng_ce}, {2'b10, 1'b0});
        end
        abort = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_rest("abort_idle");
        start_frame();

        // Random frame, then start held through ack into a new frame
        feed(NS, 1'b0);
        to_drain();
        drain_run($urandom_range(2, 30));
        finish_result(SW'($urandom), 1'b1);

        // Timeout: no td_done, error exactly TO cycles after drain entry
        feed(NS, 1'b0);
        to_drain();
        for (int i = 1; i <= TO; i++) begin
            tick();
            di++;
            if (i < TO) begin
                chk("to_pending", {err_code, busy}, {2'b00, 1'b1});
                chk("to_ce", eng_ce, 32'(di % CP == 1));
            end else begin
                chk("to_expired", {err_code, busy, eng_rst, eng_ce, done},
                    {2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_rest("to_idle");

        // td_done on the expiry cycle wins over timeout
        start_frame();
        feed(NS, 1'b0);
        to_drain();
        drain_run(TO - 1);
        finish_result(SW'($urandom), 1'b0);

        // Reset in the middle of DRAIN, then a clean frame from sample 1
        start_frame();
        feed(NS, 1'b0);
        to_drain();
        drain_run($urandom_range(1, 20));
        reset_n = 1'b0;
        tick();
        exp_result = '0;
        chk_rest("mid_reset");
        reset_n = 1'b1;
        start_frame();
        feed(NS, 1'b0);
        to_drain();
        sync_pulse();
        finish_result(SW'($urandom), 1'b0);

        // A few more random frames
        for (int f = 0; f < 3; f++) begin
            start_frame();
            feed(NS, 1'b0);
            to_drain();
            drain_run($urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) sync_pulse();
            finish_result(SW'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
